// File: rtl/beep_pkg.sv
// beep_pkg: shared state encoding, owner codes and pattern window constants
// for the buzzer scheduler.
package beep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLICK,
        ST_CHIME,
        ST_ALARM,
        ST_SNOOZE
    } state_t;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_CLICK = 2'd1;
    localparam logic [1:0] SRC_CHIME = 2'd2;
    localparam logic [1:0] SRC_ALARM = 2'd3;

    localparam logic [9:0] WIN_100   = 10'd100;
    localparam logic [9:0] WIN_200   = 10'd200;
    localparam logic [9:0] WIN_300   = 10'd300;
    localparam logic [9:0] WIN_400   = 10'd400;
    localparam logic [9:0] WIN_500   = 10'd500;
    localparam logic [9:0] FRAME_END = 10'd999;

    // SNOOZE still belongs to the alarm from the user's point of view
    function automatic logic [1:0] src_of(input state_t s);
        return (s == ST_ALARM || s == ST_SNOOZE) ? SRC_ALARM :
               (s == ST_CHIME) ? SRC_CHIME :
               (s == ST_CLICK) ? SRC_CLICK : SRC_NONE;
    endfunction

endpackage

// File: rtl/beep_pattern_gen.sv
// beep_pattern_gen: combinational on/off gate and tone bit for the current
// sound, derived from the millisecond position and the free-running divider.
module beep_pattern_gen
    import beep_pkg::*;
(
    input  state_t     state,
    input  logic [9:0] ms_cnt,
    input  logic [1:0] tone_div,
    output logic       gate,
    output logic       tone
);

    always_comb begin
        gate = (state == ST_CLICK)
            || (state == ST_CHIME && ms_cnt < WIN_200)
            || (state == ST_ALARM && (ms_cnt < WIN_100
                || (ms_cnt >= WIN_200 && ms_cnt < WIN_300)
                || (ms_cnt >= WIN_400 && ms_cnt < WIN_500)));
        tone = (state == ST_CHIME) ? tone_div[1] : tone_div[0];
    end

endmodule

// File: rtl/beep_scheduler.sv
// beep_scheduler: fixed-priority owner of the buzzer for alarm, hourly chime
// and key click, with per-source timing, rhythm, tone, snooze and stop.
module beep_scheduler
    import beep_pkg::*;
#(
    parameter int ALARM_SECS  = 30,
    parameter int CHIME_SECS  = 5,
    parameter int CLICK_MS    = 50,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk_1khz,
    input  logic       switch_clr,
    input  logic       alarm_enable,
    input  logic       alarm_req,
    input  logic       chime_req,
    input  logic       click_req,
    input  logic       snooze,
    input  logic       stop,
    output logic       beep,
    output logic [1:0] active_src,
    output logic       snoozed,
    output logic       busy
);

    localparam int SEC_AC  = (ALARM_SECS > CHIME_SECS) ? ALARM_SECS : CHIME_SECS;
    localparam int SEC_MAX = (SEC_AC > SNOOZE_SECS) ? SEC_AC : SNOOZE_SECS;
    localparam int SW      = $clog2(SEC_MAX + 1);
    localparam int CW      = $clog2(CLICK_MS + 1);
    localparam int NW      = $clog2(MAX_SNOOZE + 1);

    state_t          state_q, state_d;
    logic [9:0]      ms_cnt_q, ms_cnt_d;
    logic [SW-1:0]   sec_cnt_q, sec_cnt_d;
    logic [CW-1:0]   click_cnt_q, click_cnt_d;
    logic [NW-1:0]   snooze_cnt_q, snooze_cnt_d;
    logic [1:0]      tone_div_q, tone_div_d;
    logic            beep_q, beep_d;
    logic [1:0]      active_src_q, active_src_d;
    logic            snoozed_q, snoozed_d;
    logic            busy_q, busy_d;
    logic            load, frame_end, expire, snooze_ok, gate, tone;

    beep_pattern_gen u_pattern (
        .state    (state_q),
        .ms_cnt   (ms_cnt_q),
        .tone_div (tone_div_q),
        .gate     (gate),
        .tone     (tone)
    );

    always_comb begin
        frame_end    = ms_cnt_q == FRAME_END;
        expire       = frame_end && sec_cnt_q == SW'(1);
        snooze_ok    = snooze_cnt_q < NW'(MAX_SNOOZE);
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        load         = 1'b0;
        // first matching event wins; everything below it is dropped this cycle
        if (stop && state_q inside {ST_ALARM, ST_SNOOZE, ST_CHIME}) begin
            state_d      = ST_IDLE;
            snooze_cnt_d = '0;
            load         = 1'b1;
        end else if (!alarm_enable && state_q inside {ST_ALARM, ST_SNOOZE}) begin
            state_d      = ST_IDLE;
            snooze_cnt_d = '0;
            load         = 1'b1;
        end else if (snooze && state_q == ST_ALARM) begin
            state_d      = snooze_ok ? ST_SNOOZE : ST_IDLE;
            snooze_cnt_d = snooze_ok ? snooze_cnt_q + 1'b1 : '0;
            load         = 1'b1;
        end else if (alarm_req && alarm_enable && state_q != ST_SNOOZE) begin
            state_d = ST_ALARM;
            load    = 1'b1;
        end else if (chime_req && state_q inside {ST_IDLE, ST_CLICK}) begin
            state_d = ST_CHIME;
            load    = 1'b1;
        end else if (click_req && state_q inside {ST_IDLE, ST_CLICK}) begin
            state_d = ST_CLICK;
            load    = 1'b1;
        end else if (expire && state_q inside {ST_ALARM, ST_CHIME}) begin
            state_d      = ST_IDLE;
            snooze_cnt_d = (state_q == ST_ALARM) ? '0 : snooze_cnt_q;
            load         = 1'b1;
        end else if (expire && state_q == ST_SNOOZE) begin
            state_d = ST_ALARM;
            load    = 1'b1;
        end else if (state_q == ST_CLICK && click_cnt_q == CW'(CLICK_MS - 1)) begin
            state_d = ST_IDLE;
            load    = 1'b1;
        end
        ms_cnt_d     = (load || frame_end) ? '0 : ms_cnt_q + 10'd1;
        sec_cnt_d    = load ? ((state_d == ST_ALARM)  ? SW'(ALARM_SECS)  :
                               (state_d == ST_CHIME)  ? SW'(CHIME_SECS)  :
                               (state_d == ST_SNOOZE) ? SW'(SNOOZE_SECS) : '0) :
                       (frame_end && sec_cnt_q != '0) ? sec_cnt_q - 1'b1 : sec_cnt_q;
        click_cnt_d  = load ? '0 : (state_q == ST_CLICK) ? click_cnt_q + 1'b1 : click_cnt_q;
        tone_div_d   = tone_div_q + 2'd1;
        beep_d       = !load && gate && tone;
        active_src_d = src_of(state_d);
        snoozed_d    = state_d == ST_SNOOZE;
        busy_d       = state_d != ST_IDLE;
    end

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state_q      <= ST_IDLE;
            ms_cnt_q     <= '0;
            sec_cnt_q    <= '0;
            click_cnt_q  <= '0;
            snooze_cnt_q <= '0;
            tone_div_q   <= '0;
            beep_q       <= 1'b0;
            active_src_q <= SRC_NONE;
            snoozed_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ms_cnt_q     <= ms_cnt_d;
            sec_cnt_q    <= sec_cnt_d;
            click_cnt_q  <= click_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            tone_div_q   <= tone_div_d;
            beep_q       <= beep_d;
            active_src_q <= active_src_d;
            snoozed_q    <= snoozed_d;
            busy_q       <= busy_d;
        end
    end

    assign beep       = beep_q;
    assign active_src = active_src_q;
    assign snoozed    = snoozed_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// tb_beep_scheduler: directed checks of arbitration, timing, rhythm, snooze,
// stop and asynchronous reset, using shortened durations.
module tb_beep_scheduler;

    localparam logic [4:0] P_ALARM  = 5'b10000;
    localparam logic [4:0] P_CHIME  = 5'b01000;
    localparam logic [4:0] P_CLICK  = 5'b00100;
    localparam logic [4:0] P_SNOOZE = 5'b00010;
    localparam logic [4:0] P_STOP   = 5'b00001;

    logic       clk_1khz = 1'b0;
    logic       switch_clr = 1'b0;
    logic       alarm_enable = 1'b1;
    logic       alarm_req = 1'b0, chime_req = 1'b0, click_req = 1'b0, snooze = 1'b0, stop = 1'b0;
    logic       beep, snoozed, busy;
    logic [1:0] active_src;
    int         errors = 0;
    int         checks = 0;

    always #5 clk_1khz = ~clk_1khz;

    beep_scheduler #(
        .ALARM_SECS  (3),
        .CHIME_SECS  (2),
        .CLICK_MS    (50),
        .SNOOZE_SECS (2),
        .MAX_SNOOZE  (3)
    ) dut (
        .clk_1khz     (clk_1khz),
        .switch_clr   (switch_clr),
        .alarm_enable (alarm_enable),
        .alarm_req    (alarm_req),
        .chime_req    (chime_req),
        .click_req    (click_req),
        .snooze       (snooze),
        .stop         (stop),
        .beep         (beep),
        .active_src   (active_src),
        .snoozed      (snoozed),
        .busy         (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_1khz);
        #1;
    endtask

    task automatic fire(input logic [4:0] m);
        {alarm_req, chime_req, click_req, snooze, stop} = m;
        step(1);
        {alarm_req, chime_req, click_req, snooze, stop} = 5'b0;
    endtask

    task automatic measure(input int n, input int src, output int highs, output int src_ok,
                           output int toggles);
        logic prev;
        highs = 0;
        src_ok = 0;
        toggles = 0;
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (beep) highs++;
            if (active_src == 2'(src)) src_ok++;
            if (i > 0 && beep != prev) toggles++;
            prev = beep;
            step(1);
        end
    endtask

    initial begin
        int h, ok, t, w;
        step(3);
        check("rst_beep", beep, 0);
        check("rst_src", active_src, 0);
        check("rst_snoozed", snoozed, 0);
        check("rst_busy", busy, 0);
        switch_clr = 1'b1;
        step(2);

        // key click: 500 Hz for the click window, then idle
        fire(P_CLICK);
        check("click_src", active_src, 1);
        check("click_busy", busy, 1);
        check("click_beep_entry", beep, 0);
        step(1);
        measure(49, 1, h, ok, t);
        check("click_src_hold", ok, 49);
        check("click_toggles", t, 48);
        check("click_end_src", active_src, 0);
        check("click_end_beep", beep, 0);
        check("click_end_busy", busy, 0);

        // chime preempts click; click during chime ignored
        fire(P_CLICK);
        step(10);
        fire(P_CHIME);
        check("chime_src", active_src, 2);
        check("chime_beep_entry", beep, 0);
        fire(P_CLICK);
        check("chime_click_ignored", active_src, 2);
        measure(1999, 2, h, ok, t);
        check("chime_highs", h, 200);
        check("chime_src_hold", ok, 1999);
        check("chime_250hz", int'(t >= 195 && t <= 210), 1);
        check("chime_end_src", active_src, 0);
        check("chime_end_busy", busy, 0);

        // disabled alarm_req ignored, enabled one preempts chime
        fire(P_CHIME);
        step(10);
        alarm_enable = 1'b0;
        fire(P_ALARM);
        check("alarm_disabled", active_src, 2);
        alarm_enable = 1'b1;
        fire(P_ALARM);
        check("alarm_preempt", active_src, 3);
        check("alarm_beep_entry", beep, 0);
        step(1);
        measure(2999, 3, h, ok, t);
        check("alarm_highs", h, 450);
        check("alarm_src_hold", ok, 2999);
        check("alarm_end_src", active_src, 0);
        check("alarm_end_busy", busy, 0);

        // snooze at 2 s, silence, then a full alarm restart
        fire(P_ALARM);
        step(2000);
        check("alarm_2s_src", active_src, 3);
        fire(P_SNOOZE);
        check("snooze_flag", snoozed, 1);
        check("snooze_src", active_src, 3);
        step(1);
        measure(1999, 3, h, ok, t);
        check("snooze_silent", h, 0);
        check("snooze_src_hold", ok, 1999);
        check("resound_src", active_src, 3);
        check("resound_snoozed", snoozed, 0);
        step(1);
        measure(2999, 3, h, ok, t);
        check("resound_highs", h, 450);
        check("resound_end_src", active_src, 0);

        // expiry cleared the count: three snoozes allowed, fourth stops
        fire(P_ALARM);
        for (int k = 0; k < 3; k++) begin
            step(5);
            fire(P_SNOOZE);
            check($sformatf("snooze%0d_flag", k + 1), snoozed, 1);
            step(1999);
            check($sformatf("snooze%0d_resound", k + 1), active_src, 3);
        end
        step(5);
        fire(P_SNOOZE);
        check("snooze4_src", active_src, 0);
        check("snooze4_busy", busy, 0);
        check("snooze4_snoozed", snoozed, 0);

        // stop beats snooze in the same cycle
        fire(P_ALARM);
        step(10);
        fire(P_SNOOZE | P_STOP);
        check("stop_snooze_src", active_src, 0);
        check("stop_snooze_snoozed", snoozed, 0);

        // disabling the alarm during snooze
        fire(P_ALARM);
        fire(P_SNOOZE);
        check("dis_pre_snoozed", snoozed, 1);
        alarm_enable = 1'b0;
        step(1);
        check("dis_src", active_src, 0);
        check("dis_snoozed", snoozed, 0);
        check("dis_busy", busy, 0);
        fire(P_ALARM);
        check("dis_idle_alarm", active_src, 0);
        alarm_enable = 1'b1;

        // asynchronous reset mid-burst
        fire(P_CHIME);
        step(20);
        w = 0;
        while (!beep && w < 8) begin
            step(1);
            w++;
        end
        check("rst_mid_beep_seen", beep, 1);
        #2 switch_clr = 1'b0;
        #1;
        check("async_beep", beep, 0);
        check("async_busy", busy, 0);
        check("async_src", active_src, 0);
        #10 switch_clr = 1'b1;
        step(1);
        fire(P_CHIME);
        check("post_rst_src", active_src, 2);
        check("post_rst_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
